uart_rx_cfg: RTL and testbench

Parametrised UART receiver, successor to the fixed 8N1 `uart_rx`. It supports 5–9 data bits, optional odd/even parity and 1 or 2 stop bits. Each bit is decided by a 3-sample majority vote at bit centre, and short start glitches are rejected. Parity errors, framing errors and line breaks are reported alongside each received word. It sits between the board RX pin and the command/packet parser; the downstream logic sees one `o_dv` pulse per completed frame.

---
 rtl/uart_rx_cfg.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5-9 data bits, optional parity, 1-2 stop bits,
// 3-sample majority voting, start-glitch rejection and break/framing/parity reporting.
module uart_rx_cfg #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_dv,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_break,
  output logic                 o_busy
);

  localparam int unsigned Cpb  = CLK_FREQ / BAUD;
  localparam int unsigned Half = Cpb / 2;
  localparam int unsigned CntW = (Cpb > 1) ? $clog2(Cpb) : 1;
  localparam int unsigned IdxW = 4;
  localparam logic        HasParity = (PARITY != 0);
  localparam logic        OddParity = (PARITY == 1);

  if (Cpb < 8) begin : gen_bad_cpb
    $error("uart_rx_cfg: CLK_FREQ/BAUD must give at least 8 clocks per bit");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : gen_bad_data_bits
    $error("uart_rx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY > 2) begin : gen_bad_parity
    $error("uart_rx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : gen_bad_stop_bits
    $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StWaitHigh
  } state_e;

  state_e               state_q, state_d;
  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic [1:0]           vld_q, vld_d;
  logic                 armed_q, armed_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 s0_q, s0_d;
  logic                 s1_q, s1_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic                 par_q, par_d;
  logic                 stop1_q, stop1_d;
  logic                 fe_q, fe_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 dv_q, dv_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 brk_q, brk_d;

  logic rxs;
  logic decide;
  logic vote;
  logic fe_next;
  logic first_stop;

  assign rxs    = sync2_q;
  assign decide = (cnt_q == CntW'(Half + 1));
  // Two earlier samples are held in s0/s1; the third is the live line.
  assign vote   = (s0_q & s1_q) | (s0_q & rxs) | (s1_q & rxs);

  always_comb begin
    sync1_d = i_rx;
    sync2_d = sync1_q;
    // The sync flops reset high, so only trust rxs once real samples have arrived.
    vld_d   = {vld_q[0], 1'b1};
    armed_d = armed_q | (vld_q[1] & rxs);

    state_d = state_q;
    cnt_d   = cnt_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    par_d   = par_q;
    stop1_d = stop1_q;
    fe_d    = fe_q;

    data_d  = data_q;
    dv_d    = 1'b0;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    brk_d   = brk_q;

    fe_next    = fe_q | ~vote;
    first_stop = (idx_q == '0) ? vote : stop1_q;

    if (state_q != StIdle) begin
      cnt_d = (cnt_q == CntW'(Cpb - 1)) ? '0 : cnt_q + CntW'(1);
    end
    if (cnt_q == CntW'(Half - 1)) s0_d = rxs;
    if (cnt_q == CntW'(Half))     s1_d = rxs;

    unique case (state_q)
      StIdle: begin
        if (armed_q && !rxs) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (decide) begin
          if (vote) begin
            state_d = StIdle;
          end else begin
            state_d = StData;
            idx_d   = '0;
            fe_d    = 1'b0;
          end
        end
      end
      StData: begin
        if (decide) begin
          shift_d = {vote, shift_q[DATA_BITS-1:1]};
          idx_d   = idx_q + IdxW'(1);
          if (idx_q == IdxW'(DATA_BITS - 1)) begin
            state_d = HasParity ? StParity : StStop;
            idx_d   = '0;
          end
        end
      end
      StParity: begin
        if (decide) begin
          par_d   = vote;
          state_d = StStop;
        end
      end
      StStop: begin
        if (decide) begin
          if (idx_q == '0) stop1_d = vote;
          if (idx_q == IdxW'(STOP_BITS - 1)) begin
            data_d  = shift_q;
            dv_d    = 1'b1;
            perr_d  = HasParity & (par_q != ((^shift_q) ^ OddParity));
            brk_d   = (shift_q == '0) & ~(HasParity & par_q) & ~first_stop;
            ferr_d  = fe_next;
            fe_d    = fe_next;
            // Leave mid-stop on a clean frame so a back-to-back start is not missed.
            state_d = fe_next ? StWaitHigh : StIdle;
          end else begin
            fe_d  = fe_next;
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      StWaitHigh: begin
        if (rxs) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      vld_q   <= '0;
      armed_q <= 1'b0;
      cnt_q   <= '0;
      s0_q    <= 1'b1;
      s1_q    <= 1'b1;
      shift_q <= '0;
      idx_q   <= '0;
      par_q   <= 1'b0;
      stop1_q <= 1'b1;
      fe_q    <= 1'b0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      vld_q   <= vld_d;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      stop1_q <= stop1_d;
      fe_q    <= fe_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      brk_q   <= brk_d;
    end
  end

  assign o_data       = data_q;
  assign o_dv         = dv_q;
  assign o_parity_err = perr_q;
  assign o_frame_err  = ferr_q;
  assign o_break      = brk_q;
  assign o_busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: three configurations (8N1, 7E1, 9N2) on one clock,
// o_dv pulses captured by per-instance monitors and checked inline per scenario.
module tb_uart_rx_cfg;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;

  logic [7:0] d_a;
  logic [6:0] d_b;
  logic [8:0] d_c;
  logic dv_a, pe_a, fe_a, bk_a, bz_a;
  logic dv_b, pe_b, fe_b, bk_b, bz_b;
  logic dv_c, pe_c, fe_c, bk_c, bz_c;

  int unsigned cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  int dv_cnt [3];
  logic [8:0]  cap_d [3][16];
  logic [2:0]  cap_f [3][16];
  int unsigned cap_t [3][16];

  uart_rx_cfg u_def (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx_a), .o_data(d_a), .o_dv(dv_a),
    .o_parity_err(pe_a), .o_frame_err(fe_a), .o_break(bk_a), .o_busy(bz_a)
  );

  uart_rx_cfg #(
    .CLK_FREQ(50_000_000), .BAUD(1_000_000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)
  ) u_par (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx_b), .o_data(d_b), .o_dv(dv_b),
    .o_parity_err(pe_b), .o_frame_err(fe_b), .o_break(bk_b), .o_busy(bz_b)
  );

  uart_rx_cfg #(
    .CLK_FREQ(50_000_000), .BAUD(1_000_000), .DATA_BITS(9), .PARITY(0), .STOP_BITS(2)
  ) u_stp (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx_c), .o_data(d_c), .o_dv(dv_c),
    .o_parity_err(pe_c), .o_frame_err(fe_c), .o_break(bk_c), .o_busy(bz_c)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dv_a === 1'b1) begin
      cap_d[0][dv_cnt[0] % 16] = {1'b0, d_a};
      cap_f[0][dv_cnt[0] % 16] = {pe_a, fe_a, bk_a};
      cap_t[0][dv_cnt[0] % 16] = cyc;
      dv_cnt[0] = dv_cnt[0] + 1;
    end
    if (dv_b === 1'b1) begin
      cap_d[1][dv_cnt[1] % 16] = {2'b00, d_b};
      cap_f[1][dv_cnt[1] % 16] = {pe_b, fe_b, bk_b};
      cap_t[1][dv_cnt[1] % 16] = cyc;
      dv_cnt[1] = dv_cnt[1] + 1;
    end
    if (dv_c === 1'b1) begin
      cap_d[2][dv_cnt[2] % 16] = d_c;
      cap_f[2][dv_cnt[2] % 16] = {pe_c, fe_c, bk_c};
      cap_t[2][dv_cnt[2] % 16] = cyc;
      dv_cnt[2] = dv_cnt[2] + 1;
    end
  end

  task automatic drive(input int sel, input logic v);
    case (sel)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  // bits[0] goes out first; each bit is held for cpb clock cycles.
  task automatic send(input int sel, input logic [15:0] bits, input int n, input int cpb);
    for (int i = 0; i < n; i++) begin
      drive(sel, bits[i]);
      repeat (cpb) @(negedge clk);
    end
  endtask

  task automatic wait_dv(input int sel, input int target, input int budget);
    for (int i = 0; i < budget && dv_cnt[sel] < target; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (d_a !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", d_a); end
    n_vec++;
    if ({dv_a, pe_a, fe_a, bk_a, bz_a} !== 5'b0) begin
      n_err++; $display("FAIL reset_flags: got %b want 00000", {dv_a, pe_a, fe_a, bk_a, bz_a});
    end
    n_vec++;
    if ({d_b, d_c} !== 16'h0) begin
      n_err++; $display("FAIL reset_data_bc: got %h want 0000", {d_b, d_c});
    end
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    n_vec++;
    if (bz_a !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b want 0", bz_a); end
  endtask

  task automatic test_back_to_back();
    int base;
    int unsigned t0;
    int k0, k1;
    base = dv_cnt[0];
    t0 = cyc;
    k0 = base % 16;
    k1 = (base + 1) % 16;
    send(0, 16'({1'b1, 8'h37, 1'b0}), 10, 434);
    send(0, 16'({1'b1, 8'h03, 1'b0}), 10, 434);
    wait_dv(0, base + 2, 500);
    n_vec++;
    if (dv_cnt[0] !== base + 2) begin
      n_err++; $display("FAIL b2b_count: got %0d want %0d", dv_cnt[0] - base, 2);
    end
    n_vec++;
    if (cap_d[0][k0] !== 9'h037) begin
      n_err++; $display("FAIL b2b_data0: got %h want 037", cap_d[0][k0]);
    end
    n_vec++;
    if (cap_f[0][k0] !== 3'b000) begin
      n_err++; $display("FAIL b2b_flags0: got %b want 000", cap_f[0][k0]);
    end
    n_vec++;
    if (cap_t[0][k0] - t0 !== 32'd4128) begin
      n_err++; $display("FAIL b2b_latency: got %0d want 4128", cap_t[0][k0] - t0);
    end
    n_vec++;
    if (cap_d[0][k1] !== 9'h003) begin
      n_err++; $display("FAIL b2b_data1: got %h want 003", cap_d[0][k1]);
    end
    n_vec++;
    if (cap_f[0][k1] !== 3'b000) begin
      n_err++; $display("FAIL b2b_flags1: got %b want 000", cap_f[0][k1]);
    end
    n_vec++;
    if ((cap_t[0][k1] - cap_t[0][k0] < 3906) || (cap_t[0][k1] - cap_t[0][k0] > 4774)) begin
      n_err++; $display("FAIL b2b_spacing: got %0d want 4340+-434", cap_t[0][k1] - cap_t[0][k0]);
    end
  endtask

  task automatic test_parity();
    int base;
    int k0, k1;
    base = dv_cnt[1];
    k0 = base % 16;
    k1 = (base + 1) % 16;
    repeat (20) @(negedge clk);
    // 0x55 has four ones, so even parity is 0.
    send(1, 16'({1'b1, 1'b0, 7'h55, 1'b0}), 10, 50);
    repeat (20) @(negedge clk);
    send(1, 16'({1'b1, 1'b1, 7'h55, 1'b0}), 10, 50);
    wait_dv(1, base + 2, 200);
    n_vec++;
    if (dv_cnt[1] !== base + 2) begin
      n_err++; $display("FAIL par_count: got %0d want %0d", dv_cnt[1] - base, 2);
    end
    n_vec++;
    if (cap_d[1][k0] !== 9'h055) begin
      n_err++; $display("FAIL par_good_data: got %h want 055", cap_d[1][k0]);
    end
    n_vec++;
    if (cap_f[1][k0] !== 3'b000) begin
      n_err++; $display("FAIL par_good_flags: got %b want 000", cap_f[1][k0]);
    end
    n_vec++;
    if (cap_d[1][k1] !== 9'h055) begin
      n_err++; $display("FAIL par_bad_data: got %h want 055", cap_d[1][k1]);
    end
    n_vec++;
    if (cap_f[1][k1] !== 3'b100) begin
      n_err++; $display("FAIL par_bad_flags: got %b want 100", cap_f[1][k1]);
    end
  endtask

  task automatic test_stop2();
    int base;
    int k0;
    base = dv_cnt[2];
    k0 = base % 16;
    repeat (20) @(negedge clk);
    send(2, 16'({1'b0, 1'b1, 9'h1A5, 1'b0}), 12, 50);
    n_vec++;
    if (bz_c !== 1'b1) begin n_err++; $display("FAIL stop2_busy_low: got %b want 1", bz_c); end
    drive(2, 1'b1);
    repeat (5) @(negedge clk);
    n_vec++;
    if (bz_c !== 1'b0) begin n_err++; $display("FAIL stop2_busy_high: got %b want 0", bz_c); end
    wait_dv(2, base + 1, 200);
    n_vec++;
    if (dv_cnt[2] !== base + 1) begin
      n_err++; $display("FAIL stop2_count: got %0d want %0d", dv_cnt[2] - base, 1);
    end
    n_vec++;
    if (cap_d[2][k0] !== 9'h1A5) begin
      n_err++; $display("FAIL stop2_data: got %h want 1a5", cap_d[2][k0]);
    end
    n_vec++;
    if (cap_f[2][k0] !== 3'b010) begin
      n_err++; $display("FAIL stop2_flags: got %b want 010", cap_f[2][k0]);
    end
  endtask

  task automatic test_break();
    int base;
    int k0, k1;
    base = dv_cnt[0];
    k0 = base % 16;
    k1 = (base + 1) % 16;
    drive(0, 1'b0);
    repeat (30 * 434) @(negedge clk);
    n_vec++;
    if (dv_cnt[0] !== base + 1) begin
      n_err++; $display("FAIL brk_count: got %0d want %0d", dv_cnt[0] - base, 1);
    end
    n_vec++;
    if (bz_a !== 1'b1) begin n_err++; $display("FAIL brk_busy_low: got %b want 1", bz_a); end
    drive(0, 1'b1);
    repeat (5) @(negedge clk);
    n_vec++;
    if (bz_a !== 1'b0) begin n_err++; $display("FAIL brk_busy_high: got %b want 0", bz_a); end
    n_vec++;
    if (cap_d[0][k0] !== 9'h000) begin
      n_err++; $display("FAIL brk_data: got %h want 000", cap_d[0][k0]);
    end
    n_vec++;
    if (cap_f[0][k0] !== 3'b011) begin
      n_err++; $display("FAIL brk_flags: got %b want 011", cap_f[0][k0]);
    end
    repeat (10) @(negedge clk);
    send(0, 16'({1'b1, 8'hA3, 1'b0}), 10, 434);
    wait_dv(0, base + 2, 500);
    n_vec++;
    if (dv_cnt[0] !== base + 2) begin
      n_err++; $display("FAIL brk_after_count: got %0d want %0d", dv_cnt[0] - base, 2);
    end
    n_vec++;
    if ({cap_f[0][k1], cap_d[0][k1]} !== {3'b000, 9'h0A3}) begin
      n_err++; $display("FAIL brk_after_frame: got %b/%h want 000/0a3", cap_f[0][k1], cap_d[0][k1]);
    end
  endtask

  task automatic test_glitch();
    int base;
    base = dv_cnt[0];
    repeat (10) @(negedge clk);
    drive(0, 1'b0);
    repeat (3) @(negedge clk);
    n_vec++;
    if (bz_a !== 1'b1) begin n_err++; $display("FAIL glitch_start: got %b want 1", bz_a); end
    repeat (2) @(negedge clk);
    drive(0, 1'b1);
    // Now 5 cycles after the low drive; START must be left by E+2+HALF+2 = 222 negedges in.
    repeat (217) @(negedge clk);
    n_vec++;
    if (bz_a !== 1'b0) begin n_err++; $display("FAIL glitch_busy: got %b want 0", bz_a); end
    repeat (20) @(negedge clk);
    n_vec++;
    if (dv_cnt[0] !== base) begin
      n_err++; $display("FAIL glitch_dv: got %0d want 0", dv_cnt[0] - base);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    int k0;
    base = dv_cnt[0];
    k0 = base % 16;
    repeat (10) @(negedge clk);
    send(0, 16'b1110, 4, 434);
    n_vec++;
    if (bz_a !== 1'b1) begin n_err++; $display("FAIL rst_mid_busy: got %b want 1", bz_a); end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({d_a, dv_a, pe_a, fe_a, bk_a, bz_a} !== 13'h0) begin
      n_err++; $display("FAIL rst_mid_outputs: got %h want 0000", {d_a, dv_a, pe_a, fe_a, bk_a, bz_a});
    end
    drive(0, 1'b0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (2000) @(negedge clk);
    n_vec++;
    if ({dv_cnt[0] != base, bz_a} !== 2'b00) begin
      n_err++; $display("FAIL rst_low_release: got dv_seen=%0d busy=%b want 0/0",
                        dv_cnt[0] - base, bz_a);
    end
    drive(0, 1'b1);
    repeat (10) @(negedge clk);
    send(0, 16'({1'b1, 8'h81, 1'b0}), 10, 434);
    wait_dv(0, base + 1, 500);
    n_vec++;
    if (dv_cnt[0] !== base + 1) begin
      n_err++; $display("FAIL rst_after_count: got %0d want 1", dv_cnt[0] - base);
    end
    n_vec++;
    if ({cap_f[0][k0], cap_d[0][k0]} !== {3'b000, 9'h081}) begin
      n_err++; $display("FAIL rst_after_frame: got %b/%h want 000/081", cap_f[0][k0], cap_d[0][k0]);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_parity();
    test_stop2();
    test_break();
    test_glitch();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_600_000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1, "watchdog expired");
  end

endmodule
